// File: rtl/tdm_pkg.sv
// Shared types for the four-slot TDM receive path.
package tdm_pkg;

  localparam int unsigned NUM_SLOTS = 4;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [1:0] slot_idx_t;

endpackage

// File: rtl/tdm_slot_shifter.sv
// MSB-first slot shift register; word_o presents the assembled word including the live bit.
module tdm_slot_shifter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         restart_i,
  input  logic         last_i,
  input  logic         bit_i,
  output logic [W-1:0] word_o,
  output logic         done_o
);

  // Only W-1 bits are stored: the final bit of a slot is taken straight from bit_i.
  logic [W-2:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (en_i) begin
      if (restart_i) begin
        sh_d    = '0;
        sh_d[0] = bit_i;
      end else if (last_i) begin
        sh_d = '0;
      end else begin
        sh_d = (W-1)'({sh_q, bit_i});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign word_o = {sh_q, bit_i};
  assign done_o = en_i & last_i & ~restart_i;

endmodule

// File: rtl/tdm_demux4.sv
// Framed serial-to-parallel demultiplexer: four W-bit lanes with per-lane strobes and sync tracking.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             fsync,
  output logic [4*W-1:0]   dout,
  output logic [3:0]       dout_vld,
  output logic             frame_done,
  output logic             frame_err,
  output logic             locked
);

  localparam int unsigned    BW        = $clog2(W);
  localparam logic [BW-1:0]  LAST_BIT  = BW'(W-1);
  localparam logic [BW-1:0]  ONE       = BW'(1);
  localparam slot_idx_t      LAST_SLOT = slot_idx_t'(NUM_SLOTS-1);

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  slot_idx_t       slot_cnt_q, slot_cnt_d;
  logic [W-1:0]    lane_q [NUM_SLOTS];
  logic [3:0]      vld_q, vld_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            sh_en, sh_restart, sh_last, sh_done;
  logic [W-1:0]    word;
  logic            at_boundary;

  assign sh_last     = (bit_cnt_q == LAST_BIT);
  assign at_boundary = (bit_cnt_q == '0) && (slot_cnt_q == '0);

  tdm_slot_shifter #(.W(W)) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (sh_en),
    .restart_i (sh_restart),
    .last_i    (sh_last),
    .bit_i     (din),
    .word_o    (word),
    .done_o    (sh_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // An fsync at the expected boundary and a mid-frame resync share one path;
  // they differ only in whether frame_err is raised.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    slot_cnt_d = slot_cnt_q;
    sh_en      = 1'b0;
    sh_restart = 1'b0;
    vld_d      = '0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            state_d    = RUN;
            sh_en      = 1'b1;
            sh_restart = 1'b1;
            bit_cnt_d  = ONE;
            slot_cnt_d = '0;
          end
        end
        RUN: begin
          if (at_boundary && !fsync) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (fsync) begin
            err_d      = ~at_boundary;
            sh_en      = 1'b1;
            sh_restart = 1'b1;
            bit_cnt_d  = ONE;
            slot_cnt_d = '0;
          end else begin
            sh_en = 1'b1;
            if (sh_last) begin
              bit_cnt_d         = '0;
              slot_cnt_d        = slot_cnt_q + 2'd1;
              vld_d[slot_cnt_q] = 1'b1;
              done_d            = (slot_cnt_q == LAST_SLOT);
            end else begin
              bit_cnt_d = bit_cnt_q + ONE;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      slot_cnt_q <= '0;
      vld_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (sh_done) begin
        lane_q[slot_cnt_q] <= word;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      dout[k*W +: W] = lane_q[k];
    end
  end

  assign dout_vld   = vld_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign locked     = (state_q == RUN);

endmodule
